// File: rtl/jk_pkg.sv
// Shared JK op encoding for the scheduler and the bank cells.
package jk_pkg;

  typedef logic [1:0] jk_op_t;

  localparam jk_op_t JK_HOLD = 2'b00;
  localparam jk_op_t JK_RST  = 2'b01;
  localparam jk_op_t JK_SET  = 2'b10;
  localparam jk_op_t JK_TGL  = 2'b11;

endpackage : jk_pkg

// File: rtl/jk_bank_sched_if.sv
// Requester/bank bus of the JK bank scheduler.
interface jk_bank_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH),
  parameter int unsigned IDW   = $clog2(NREQ)
);

  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [WIDTH-1:0]     q;
  logic                 done_valid;
  logic [IDW-1:0]       done_id;

  modport master (
    output req_valid, req_op, req_idx,
    input  req_ready, q, done_valid, done_id
  );

  modport slave (
    input  req_valid, req_op, req_idx,
    output req_ready, q, done_valid, done_id
  );

endinterface : jk_bank_sched_if

// File: rtl/jk_bank_sched_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot priority search.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic            advance
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] pos_c;
  logic [PW-1:0] gid_c;
  logic          found_c;

  // First valid requester starting at the pointer, wrapping; nothing while in reset.
  always_comb begin
    gnt     = '0;
    found_c = 1'b0;
    pos_c   = '0;
    if (rst) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        pos_c = PW'((32'(ptr_q) + off) % NREQ);
        if (!found_c && req[pos_c]) begin
          gnt[pos_c] = 1'b1;
          found_c    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gid_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) gid_c = PW'(i);
    end
    ptr_d = ptr_q;
    if (advance) ptr_d = (32'(gid_c) == NREQ - 1) ? '0 : gid_c + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule : rr_arbiter

// File: rtl/jk_ff.sv
// Single JK flip-flop cell with synchronous active-high reset.
module jk_ff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    unique case (jk_op_t'({j, k}))
      JK_HOLD: q_d = q_q;
      JK_RST:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule : jk_ff

// File: rtl/jk_bank_sched.sv
// Round-robin command scheduler driving a shared bank of JK cells.
module jk_bank_sched
  import jk_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_sched_if.slave   bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]  gnt_c;
  logic             xfer_c;
  logic [IDW-1:0]   gid_c;
  int unsigned      sel_c;
  logic [WIDTH-1:0] q_c;

  logic             cmd_v_q,   cmd_v_d;
  jk_op_t           cmd_op_q,  cmd_op_d;
  logic [IDXW-1:0]  cmd_idx_q, cmd_idx_d;
  logic [IDW-1:0]   cmd_id_q,  cmd_id_d;
  logic             done_valid_q;
  logic [IDW-1:0]   done_id_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .gnt     (gnt_c),
    .advance (xfer_c)
  );

  assign bus.req_ready = gnt_c;
  assign xfer_c        = |(bus.req_valid & gnt_c);

  // Capture the winner's command; an idle cycle loads an empty command.
  always_comb begin
    gid_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) gid_c = IDW'(i);
    end
    sel_c     = 32'(gid_c);
    cmd_v_d   = xfer_c;
    cmd_op_d  = cmd_op_q;
    cmd_idx_d = cmd_idx_q;
    cmd_id_d  = cmd_id_q;
    if (xfer_c) begin
      cmd_op_d  = jk_op_t'(bus.req_op[2*sel_c +: 2]);
      cmd_idx_d = bus.req_idx[IDXW*sel_c +: IDXW];
      cmd_id_d  = gid_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_v_q      <= 1'b0;
      cmd_op_q     <= JK_HOLD;
      cmd_idx_q    <= '0;
      cmd_id_q     <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
    end else begin
      cmd_v_q      <= cmd_v_d;
      cmd_op_q     <= cmd_op_d;
      cmd_idx_q    <= cmd_idx_d;
      cmd_id_q     <= cmd_id_d;
      done_valid_q <= cmd_v_q;
      done_id_q    <= cmd_id_q;
    end
  end

  // Only the addressed cell sees the op; an out-of-range index matches no cell.
  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    logic hit_c;
    assign hit_c = cmd_v_q && (cmd_idx_q == IDXW'(c));
    jk_ff u_ff (
      .clk (clk),
      .rst (!rst),
      .j   (hit_c & cmd_op_q[1]),
      .k   (hit_c & cmd_op_q[0]),
      .q   (q_c[c])
    );
  end

  assign bus.q          = q_c;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;

endmodule : jk_bank_sched
